st_h2c_port_arbiter: RTL and testbench
======================================

Name: st_h2c_port_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one H2C AXI-Stream sink between NUM_PORTS upstream H2C sources.
- The sink is the stream checker/FIFO write path.
- Holds a grant from first beat to tlast, so packets never interleave.
- Provides run gating, a per-port enable mask, LFSR-driven back-pressure injection for stress testing, and packet/beat statistics for the host register file.

Parameters:
BIT_WIDTH, 64, data width of every stream (64/128/256/512)
NUM_PORTS, 4, number of upstream requesters (2..8)
PORT_W, 2, width of grant index; equals clog2(NUM_PORTS)
LFSR_SEED, 16'hACE1, reset value of back-pressure LFSR (non-zero)

Ports:
axi_aclk  in  1  clock
axi_aresetn  in  1  asynchronous active-low reset
control_reg  in  32  bit1 = back-pressure enable; other bits ignored
control_run  in  1  1 = new grants allowed
port_en  in  NUM_PORTS  per-port request mask
clr_count  in  1  synchronous clear of statistics
s_tdata  in  NUM_PORTS*BIT_WIDTH  source data, port i at [i*BIT_WIDTH +: BIT_WIDTH]
s_tvalid  in  NUM_PORTS  source valid
s_tlast  in  NUM_PORTS  source last
s_tuser_qid  in  NUM_PORTS*11  source qid
s_tready  out  NUM_PORTS  source ready
m_tdata  out  BIT_WIDTH  granted data
m_tvalid  out  1  granted valid
m_tlast  out  1  granted last
m_tuser_qid  out  11  granted qid
m_tready  in  1  sink ready
grant_valid  out  1  a packet is in progress
grant_id  out  PORT_W  index of granted port
pkt_count  out  32  completed packets
beat_count  out  32  transferred beats

Behaviour:
- Reset values: state=IDLE; last_grant=NUM_PORTS-1 so port 0 wins first; lfsr=LFSR_SEED; grant_valid=0; grant_id=0; s_tready=0; m_tvalid=0; counters=0.
- Requests: req[i] = s_tvalid[i] & port_en[i].
- FSM, two states:
  - IDLE: if control_run & |req, registered grant goes to the first set req searching last_grant+1, +2, … modulo NUM_PORTS. Next state is BUSY and grant_valid=1. Otherwise remain IDLE.
  - BUSY: on m_tvalid & m_tready & m_tlast, record last_grant=grant_id, then go to IDLE with grant_valid=0.
  - A packet costs exactly 1 arbitration cycle. First beat can transfer on the cycle after the request is seen (latency 1).
  - Successive packets have one idle cycle between them.
- Datapath is combinational with no added latency:
  - m_tdata, m_tlast and m_tuser_qid come from the granted port whenever grant_valid=1; they are 0 otherwise.
  - m_tvalid = grant_valid & s_tvalid[g] & ~stall.
  - s_tready[g] = grant_valid & m_tready & ~stall; all other s_tready bits are 0.
  - m_tvalid never depends on m_tready.
- Back-pressure:
  - The 16-bit Fibonacci LFSR with taps 16,14,13,11 shifts every cycle.
  - stall = control_reg[1] & lfsr[0].
  - When stall=1, both m_tvalid and s_tready[g] are 0 that cycle.
  - With control_reg[1]=0, stall is 0.
- Behaviour changes during a packet:
  - control_run deasserting mid-packet does not break the grant; the packet completes and no new grant follows.
  - port_en clearing mid-packet likewise does not break the grant.
  - Source dropping tvalid mid-packet: grant is held indefinitely; no timeout.
- Counters:
  - beat_count increments on each m_tvalid & m_tready.
  - pkt_count increments on each such beat with m_tlast.
  - Both wrap 2^32-1 → 0.
  - clr_count has priority over increment in the same cycle and does not affect the FSM.
- Async reset mid-packet: FSM is immediately in IDLE and all readies go low. The source packet is truncated; recovery is the upstream's job.
- Single active requester: it is granted every packet, with one idle cycle between packets.

Test Plan:
- Ports 0..3 each send one 4-beat packet together, run=1, en=4'hF, m_tready=1, bp off -> grant order 0,1,2,3; each packet 4 contiguous beats; pkt_count=4, beat_count=16; 20 cycles from first request to last beat.
- Port 2 sends 3-beat packet while port 0 requests from beat 2 onward -> port 2 packet unbroken; port 0 granted next; m_tuser_qid switches only after port 2 tlast.
- port_en=4'b1101, all ports requesting -> port 1 never granted, s_tready[1]=0 throughout; order 0,2,3,0.
- control_reg=2, port 0 sends 64 single-beat packets with m_tready=1 -> stall cycles exactly match LFSR bit0 from seed 16'hACE1; final pkt_count=64 with no data loss or duplication.
- control_run drops on beat 2 of a 5-beat packet -> remaining 3 beats transfer, then grant_valid=0 with no new grant while requests pend; raising run resumes.
- Assert axi_aresetn=0 mid-packet -> s_tready, m_tvalid and grant_valid go to 0 without waiting for a clock edge. After release, port 0 wins first; clr_count pulse together with an accepted beat -> counts read 0.

Source files
------------

// File: rtl/st_h2c_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : st_h2c_port_arbiter
// Packet-granular round-robin arbiter sharing one H2C AXI-Stream sink.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module st_h2c_port_arbiter #(
  parameter int          BIT_WIDTH = 64,
  parameter int          NUM_PORTS = 4,
  parameter int          PORT_W    = 2,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                           axi_aclk,
  input  logic                           axi_aresetn,
  input  logic [31:0]                    control_reg,
  input  logic                           control_run,
  input  logic [NUM_PORTS-1:0]           port_en,
  input  logic                           clr_count,
  input  logic [NUM_PORTS*BIT_WIDTH-1:0] s_tdata,
  input  logic [NUM_PORTS-1:0]           s_tvalid,
  input  logic [NUM_PORTS-1:0]           s_tlast,
  input  logic [NUM_PORTS*11-1:0]        s_tuser_qid,
  output logic [NUM_PORTS-1:0]           s_tready,
  output logic [BIT_WIDTH-1:0]           m_tdata,
  output logic                           m_tvalid,
  output logic                           m_tlast,
  output logic [10:0]                    m_tuser_qid,
  input  logic                           m_tready,
  output logic                           grant_valid,
  output logic [PORT_W-1:0]              grant_id,
  output logic [31:0]                    pkt_count,
  output logic [31:0]                    beat_count
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]           r_state;
  logic [PORT_W-1:0]    r_grant_id;
  logic [PORT_W-1:0]    r_last_grant;
  logic [15:0]          r_lfsr;
  logic [31:0]          r_pkt_count;
  logic [31:0]          r_beat_count;

  logic [NUM_PORTS-1:0] w_req;
  logic                 w_found;
  logic [PORT_W-1:0]    w_pick;
  int                   w_idx;
  logic                 w_gv;
  logic                 w_stall;
  logic                 w_sel_valid;
  logic                 w_beat;
  logic                 w_lfsr_fb;
  logic                 w_unused_ctrl;

  assign w_req         = s_tvalid & port_en;
  assign w_gv          = (r_state == ST_BUSY);
  assign w_stall       = control_reg[1] & r_lfsr[0];
  assign w_beat        = m_tvalid & m_tready;
  assign w_lfsr_fb     = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
  assign w_unused_ctrl = ^{control_reg[31:2], control_reg[0]};

  // Rotating priority: first requester after the last completed grant.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      w_idx = (int'(r_last_grant) + k) % NUM_PORTS;
      if (!w_found && w_req[w_idx]) begin
        w_found = 1'b1;
        w_pick  = PORT_W'(w_idx);
      end
    end
  end

  always_comb begin
    m_tdata     = '0;
    m_tlast     = 1'b0;
    m_tuser_qid = '0;
    w_sel_valid = 1'b0;
    s_tready    = '0;
    if (w_gv) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (r_grant_id == PORT_W'(i)) begin
          m_tdata     = s_tdata[i*BIT_WIDTH +: BIT_WIDTH];
          m_tlast     = s_tlast[i];
          m_tuser_qid = s_tuser_qid[i*11 +: 11];
          w_sel_valid = s_tvalid[i];
          s_tready[i] = m_tready & ~w_stall;
        end
      end
    end
  end

  assign m_tvalid = w_gv & w_sel_valid & ~w_stall;

  // Grant is held from first beat until the tlast handshake.
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_state      <= ST_IDLE;
      r_grant_id   <= '0;
      r_last_grant <= PORT_W'(NUM_PORTS - 1);
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (control_run && w_found) begin
            r_state    <= ST_BUSY;
            r_grant_id <= w_pick;
          end
        end
        ST_BUSY: begin
          if (w_beat && m_tlast) begin
            r_last_grant <= r_grant_id;
            r_state      <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_lfsr <= LFSR_SEED;
    end else begin
      r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
    end
  end

  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      r_pkt_count  <= '0;
      r_beat_count <= '0;
    end else if (clr_count) begin
      r_pkt_count  <= '0;
      r_beat_count <= '0;
    end else if (w_beat) begin
      r_beat_count <= r_beat_count + 32'd1;
      if (m_tlast) begin
        r_pkt_count <= r_pkt_count + 32'd1;
      end
    end
  end

  assign grant_valid = w_gv;
  assign grant_id    = r_grant_id;
  assign pkt_count   = r_pkt_count;
  assign beat_count  = r_beat_count;

endmodule
`default_nettype wire

// File: tb/tb_st_h2c_port_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : tb_st_h2c_port_arbiter
// Directed self-checking bench for the H2C port arbiter.
// Rev    : 1.0
// ---------------------------------------------------------------------------
module tb_st_h2c_port_arbiter;
  localparam int          BW   = 64;
  localparam int          NP   = 4;
  localparam int          PW   = 2;
  localparam logic [15:0] SEED = 16'hACE1;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       control_reg;
  logic              control_run;
  logic [NP-1:0]     port_en;
  logic              clr_count;
  logic [NP*BW-1:0]  s_tdata;
  logic [NP-1:0]     s_tvalid;
  logic [NP-1:0]     s_tlast;
  logic [NP*11-1:0]  s_tuser_qid;
  logic [NP-1:0]     s_tready;
  logic [BW-1:0]     m_tdata;
  logic              m_tvalid;
  logic              m_tlast;
  logic [10:0]       m_tuser_qid;
  logic              m_tready;
  logic              grant_valid;
  logic [PW-1:0]     grant_id;
  logic [31:0]       pkt_count;
  logic [31:0]       beat_count;

  st_h2c_port_arbiter #(
    .BIT_WIDTH(BW), .NUM_PORTS(NP), .PORT_W(PW), .LFSR_SEED(SEED)
  ) dut (
    .axi_aclk(clk), .axi_aresetn(rst_n), .control_reg(control_reg),
    .control_run(control_run), .port_en(port_en), .clr_count(clr_count),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
    .s_tuser_qid(s_tuser_qid), .s_tready(s_tready), .m_tdata(m_tdata),
    .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tuser_qid(m_tuser_qid),
    .m_tready(m_tready), .grant_valid(grant_valid), .grant_id(grant_id),
    .pkt_count(pkt_count), .beat_count(beat_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            port;
    logic [BW-1:0] data;
    logic          last;
    logic [10:0]   qid;
    int            cyc;
  } beat_t;

  beat_t         log_q[$];
  int            rem[NP];
  int            left[NP];
  int            plen[NP];
  int            seq[NP];
  int            cyc;
  int            n_cmp;
  int            n_bad;
  int            stall_obs;
  logic [NP-1:0] rdy_seen;
  logic [15:0]   lfsr_m;

  // Source p drives data {p, beat sequence number} and qid 64+p.
  task automatic drive();
    for (int p = 0; p < NP; p++) begin
      s_tvalid[p]             = (rem[p] > 0);
      s_tlast[p]              = (rem[p] == 1);
      s_tdata[p*BW +: BW]     = {32'(p), 32'(seq[p])};
      s_tuser_qid[p*11 +: 11] = 11'(64 + p);
    end
  endtask

  task automatic send(input int p, input int len, input int npk);
    rem[p]  = len;
    plen[p] = len;
    left[p] = npk - 1;
    drive();
  endtask

  task automatic cycle();
    logic [NP-1:0] hs;
    logic [NP-1:0] exp_rdy;
    logic          stall;
    logic          exp_v;
    logic          exp_l;
    logic [BW-1:0] exp_d;
    logic [10:0]   exp_q;
    @(negedge clk);
    hs      = s_tvalid & s_tready;
    stall   = control_reg[1] & lfsr_m[0];
    exp_rdy = '0;
    exp_v   = 1'b0;
    exp_l   = 1'b0;
    exp_d   = '0;
    exp_q   = '0;
    if (grant_valid) begin
      exp_rdy[grant_id] = m_tready & ~stall;
      exp_v             = s_tvalid[grant_id] & ~stall;
      exp_d             = s_tdata[grant_id*BW +: BW];
      exp_l             = s_tlast[grant_id];
      exp_q             = s_tuser_qid[grant_id*11 +: 11];
      if (s_tvalid[grant_id] && !m_tvalid) stall_obs++;
    end
    n_cmp++;
    if (s_tready !== exp_rdy || m_tvalid !== exp_v || m_tdata !== exp_d ||
        m_tlast !== exp_l || m_tuser_qid !== exp_q) begin
      n_bad++;
      $display("FAIL dp_cyc%0d: rdy=%b v=%b last=%b qid=%h data=%h, expected rdy=%b v=%b last=%b qid=%h data=%h",
               cyc, s_tready, m_tvalid, m_tlast, m_tuser_qid, m_tdata,
               exp_rdy, exp_v, exp_l, exp_q, exp_d);
    end
    rdy_seen = rdy_seen | s_tready;
    if (m_tvalid && m_tready)
      log_q.push_back('{int'(grant_id), m_tdata, m_tlast, m_tuser_qid, cyc});
    @(posedge clk);
    #1;
    cyc++;
    lfsr_m = {lfsr_m[0] ^ lfsr_m[2] ^ lfsr_m[3] ^ lfsr_m[5], lfsr_m[15:1]};
    for (int p = 0; p < NP; p++) begin
      if (hs[p]) begin
        rem[p]--;
        seq[p]++;
        if (rem[p] == 0 && left[p] > 0) begin
          rem[p] = plen[p];
          left[p]--;
        end
      end
    end
    drive();
  endtask

  task automatic reset_dut();
    rst_n       = 1'b0;
    control_reg = '0;
    control_run = 1'b0;
    port_en     = '0;
    clr_count   = 1'b0;
    m_tready    = 1'b0;
    for (int p = 0; p < NP; p++) begin
      rem[p] = 0; left[p] = 0; plen[p] = 0; seq[p] = 0;
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n     = 1'b1;
    lfsr_m    = SEED;
    rdy_seen  = '0;
    stall_obs = 0;
    log_q.delete();
  endtask

  task automatic test_reset();
    int c0;
    rst_n       = 1'b0;
    control_reg = 32'd2;
    control_run = 1'b1;
    port_en     = '1;
    clr_count   = 1'b0;
    m_tready    = 1'b1;
    send(0, 2, 1);
    send(1, 2, 1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (grant_valid !== 1'b0 || grant_id !== 2'd0 || s_tready !== 4'b0 || m_tvalid !== 1'b0 ||
        m_tdata !== '0 || pkt_count !== 32'd0 || beat_count !== 32'd0) begin
      n_bad++;
      $display("FAIL reset_vals: gv=%b gid=%0d rdy=%b v=%b data=%h pkt=%0d beat=%0d, expected all zero",
               grant_valid, grant_id, s_tready, m_tvalid, m_tdata, pkt_count, beat_count);
    end
    reset_dut();
    control_run = 1'b1;
    port_en     = '1;
    m_tready    = 1'b1;
    c0 = cyc;
    send(1, 1, 1);
    send(0, 1, 1);
    repeat (5) cycle();
    n_cmp++;
    if (log_q.size() != 2) begin
      n_bad++;
      $display("FAIL first_grant_size: beats=%0d, expected 2", log_q.size());
    end else begin
      n_cmp++;
      if (log_q[0].port != 0 || log_q[0].cyc != c0 + 1 || log_q[1].port != 1 || log_q[1].cyc != c0 + 3) begin
        n_bad++;
        $display("FAIL first_grant: ports %0d,%0d at %0d,%0d, expected 0,1 at %0d,%0d",
                 log_q[0].port, log_q[1].port, log_q[0].cyc, log_q[1].cyc, c0 + 1, c0 + 3);
      end
    end
  endtask

  task automatic test_round_robin();
    int            c0;
    logic [BW-1:0] ed;
    logic          el;
    reset_dut();
    control_run = 1'b1;
    port_en     = '1;
    m_tready    = 1'b1;
    c0 = cyc;
    for (int p = 0; p < NP; p++) send(p, 4, 1);
    repeat (24) cycle();
    n_cmp++;
    if (log_q.size() != 16) begin
      n_bad++;
      $display("FAIL rr_size: beats=%0d, expected 16", log_q.size());
    end
    for (int k = 0; k < 16 && k < log_q.size(); k++) begin
      ed = {32'(k / 4), 32'(k % 4)};
      el = (k % 4 == 3);
      n_cmp++;
      if (log_q[k].port != k / 4 || log_q[k].data !== ed || log_q[k].last !== el ||
          log_q[k].cyc != c0 + 1 + 5 * (k / 4) + (k % 4)) begin
        n_bad++;
        $display("FAIL rr_beat%0d: port=%0d data=%h last=%b cyc=%0d, expected port=%0d data=%h last=%b cyc=%0d",
                 k, log_q[k].port, log_q[k].data, log_q[k].last, log_q[k].cyc,
                 k / 4, ed, el, c0 + 1 + 5 * (k / 4) + (k % 4));
      end
    end
    n_cmp++;
    if (pkt_count !== 32'd4 || beat_count !== 32'd16) begin
      n_bad++;
      $display("FAIL rr_counts: pkt=%0d beat=%0d, expected 4 16", pkt_count, beat_count);
    end
  endtask

  task automatic test_no_interleave();
    int c0;
    int ep[5] = '{2, 2, 2, 0, 0};
    int es[5] = '{0, 1, 2, 0, 1};
    int ec[5] = '{1, 2, 3, 5, 6};
    logic [BW-1:0] ed;
    reset_dut();
    control_run = 1'b1;
    port_en     = '1;
    m_tready    = 1'b1;
    c0 = cyc;
    send(2, 3, 1);
    repeat (2) cycle();
    send(0, 2, 1);
    repeat (8) cycle();
    n_cmp++;
    if (log_q.size() != 5) begin
      n_bad++;
      $display("FAIL hold_size: beats=%0d, expected 5", log_q.size());
    end
    for (int k = 0; k < 5 && k < log_q.size(); k++) begin
      ed = {32'(ep[k]), 32'(es[k])};
      n_cmp++;
      if (log_q[k].port != ep[k] || log_q[k].data !== ed || log_q[k].qid !== 11'(64 + ep[k]) ||
          log_q[k].cyc != c0 + ec[k]) begin
        n_bad++;
        $display("FAIL hold_beat%0d: port=%0d data=%h qid=%h cyc=%0d, expected port=%0d data=%h qid=%h cyc=%0d",
                 k, log_q[k].port, log_q[k].data, log_q[k].qid, log_q[k].cyc,
                 ep[k], ed, 11'(64 + ep[k]), c0 + ec[k]);
      end
    end
  endtask

  task automatic test_port_mask();
    int c0;
    int ep[8] = '{0, 0, 2, 2, 3, 3, 0, 0};
    int es[8] = '{0, 1, 0, 1, 0, 1, 2, 3};
    int ec[8] = '{1, 2, 4, 5, 7, 8, 10, 11};
    logic [BW-1:0] ed;
    reset_dut();
    control_run = 1'b1;
    port_en     = 4'b1101;
    m_tready    = 1'b1;
    c0 = cyc;
    send(0, 2, 2);
    send(1, 2, 1);
    send(2, 2, 1);
    send(3, 2, 1);
    repeat (15) cycle();
    n_cmp++;
    if (log_q.size() != 8) begin
      n_bad++;
      $display("FAIL mask_size: beats=%0d, expected 8", log_q.size());
    end
    for (int k = 0; k < 8 && k < log_q.size(); k++) begin
      ed = {32'(ep[k]), 32'(es[k])};
      n_cmp++;
      if (log_q[k].port != ep[k] || log_q[k].data !== ed || log_q[k].cyc != c0 + ec[k]) begin
        n_bad++;
        $display("FAIL mask_beat%0d: port=%0d data=%h cyc=%0d, expected port=%0d data=%h cyc=%0d",
                 k, log_q[k].port, log_q[k].data, log_q[k].cyc, ep[k], ed, c0 + ec[k]);
      end
    end
    n_cmp++;
    if (rdy_seen[1] !== 1'b0 || rem[1] != 2) begin
      n_bad++;
      $display("FAIL mask_port1: ready_seen=%b remaining=%0d, expected 0 2", rdy_seen[1], rem[1]);
    end
  endtask

  task automatic test_backpressure();
    logic [BW-1:0] ed;
    reset_dut();
    control_reg = 32'd2;
    control_run = 1'b1;
    port_en     = '1;
    m_tready    = 1'b1;
    send(0, 1, 64);
    for (int i = 0; i < 1000 && !(rem[0] == 0 && left[0] == 0); i++) cycle();
    repeat (2) cycle();
    n_cmp++;
    if (!(rem[0] == 0 && left[0] == 0)) begin
      n_bad++;
      $display("FAIL bp_timeout: remaining=%0d packets_left=%0d, expected 0 0", rem[0], left[0]);
    end
    n_cmp++;
    if (log_q.size() != 64) begin
      n_bad++;
      $display("FAIL bp_size: beats=%0d, expected 64", log_q.size());
    end
    for (int k = 0; k < 64 && k < log_q.size(); k++) begin
      ed = {32'd0, 32'(k)};
      n_cmp++;
      if (log_q[k].port != 0 || log_q[k].data !== ed || log_q[k].last !== 1'b1) begin
        n_bad++;
        $display("FAIL bp_beat%0d: port=%0d data=%h last=%b, expected 0 %h 1",
                 k, log_q[k].port, log_q[k].data, log_q[k].last, ed);
      end
    end
    n_cmp++;
    if (pkt_count !== 32'd64 || beat_count !== 32'd64) begin
      n_bad++;
      $display("FAIL bp_counts: pkt=%0d beat=%0d, expected 64 64", pkt_count, beat_count);
    end
    n_cmp++;
    if (stall_obs == 0) begin
      n_bad++;
      $display("FAIL bp_stalls: stalled cycles=%0d, expected nonzero", stall_obs);
    end
  endtask

  task automatic test_run_drop();
    int c0;
    int ep[7] = '{0, 0, 0, 0, 0, 1, 1};
    int ec[7] = '{1, 2, 3, 4, 5, 11, 12};
    reset_dut();
    control_run = 1'b1;
    port_en     = '1;
    m_tready    = 1'b1;
    c0 = cyc;
    send(0, 5, 1);
    send(1, 2, 1);
    repeat (2) cycle();
    control_run = 1'b0;
    port_en     = 4'b1110;
    repeat (8) cycle();
    n_cmp++;
    if (log_q.size() != 5 || grant_valid !== 1'b0 || rem[1] != 2) begin
      n_bad++;
      $display("FAIL run_drop: beats=%0d gv=%b port1_rem=%0d, expected 5 0 2",
               log_q.size(), grant_valid, rem[1]);
    end
    control_run = 1'b1;
    repeat (5) cycle();
    n_cmp++;
    if (log_q.size() != 7) begin
      n_bad++;
      $display("FAIL run_resume_size: beats=%0d, expected 7", log_q.size());
    end
    for (int k = 0; k < 7 && k < log_q.size(); k++) begin
      n_cmp++;
      if (log_q[k].port != ep[k] || log_q[k].cyc != c0 + ec[k] || log_q[k].last !== (k == 4 || k == 6)) begin
        n_bad++;
        $display("FAIL run_beat%0d: port=%0d cyc=%0d last=%b, expected port=%0d cyc=%0d",
                 k, log_q[k].port, log_q[k].cyc, log_q[k].last, ep[k], c0 + ec[k]);
      end
    end
  endtask

  task automatic test_async_reset_and_clear();
    int c0;
    reset_dut();
    control_run = 1'b1;
    port_en     = '1;
    m_tready    = 1'b1;
    send(0, 4, 1);
    repeat (2) cycle();
    n_cmp++;
    if (grant_valid !== 1'b1 || s_tready !== 4'b0001) begin
      n_bad++;
      $display("FAIL pre_areset: gv=%b rdy=%b, expected 1 0001", grant_valid, s_tready);
    end
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (s_tready !== 4'b0 || m_tvalid !== 1'b0 || grant_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL areset: rdy=%b v=%b gv=%b, expected 0000 0 0", s_tready, m_tvalid, grant_valid);
    end
    reset_dut();
    control_run = 1'b1;
    port_en     = '1;
    m_tready    = 1'b1;
    c0 = cyc;
    send(3, 1, 1);
    send(0, 1, 1);
    repeat (5) cycle();
    n_cmp++;
    if (log_q.size() != 2) begin
      n_bad++;
      $display("FAIL post_reset_size: beats=%0d, expected 2", log_q.size());
    end else begin
      n_cmp++;
      if (log_q[0].port != 0 || log_q[0].cyc != c0 + 1 || log_q[1].port != 3 || log_q[1].cyc != c0 + 3) begin
        n_bad++;
        $display("FAIL post_reset_order: ports %0d,%0d at %0d,%0d, expected 0,3 at %0d,%0d",
                 log_q[0].port, log_q[1].port, log_q[0].cyc, log_q[1].cyc, c0 + 1, c0 + 3);
      end
    end
    send(0, 3, 1);
    repeat (3) cycle();
    n_cmp++;
    if (pkt_count !== 32'd2 || beat_count !== 32'd4) begin
      n_bad++;
      $display("FAIL pre_clear: pkt=%0d beat=%0d, expected 2 4", pkt_count, beat_count);
    end
    clr_count = 1'b1;
    cycle();
    clr_count = 1'b0;
    n_cmp++;
    if (pkt_count !== 32'd0 || beat_count !== 32'd0 || log_q.size() != 5) begin
      n_bad++;
      $display("FAIL clear_with_beat: pkt=%0d beat=%0d beats=%0d, expected 0 0 5",
               pkt_count, beat_count, log_q.size());
    end
    repeat (2) cycle();
    n_cmp++;
    if (pkt_count !== 32'd0 || beat_count !== 32'd0) begin
      n_bad++;
      $display("FAIL clear_hold: pkt=%0d beat=%0d, expected 0 0", pkt_count, beat_count);
    end
  endtask

  initial begin
    cyc       = 0;
    n_cmp     = 0;
    n_bad     = 0;
    stall_obs = 0;
    rdy_seen  = '0;
    lfsr_m    = SEED;
    test_reset();
    test_round_robin();
    test_no_interleave();
    test_port_mask();
    test_backpressure();
    test_run_drop();
    test_async_reset_and_clear();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
